// File: rtl/cpu_clk_gen_pkg.sv
// Shared definitions for the CPU clock generator:
// mode encodings and FSM state type.
package cpu_clk_gen_pkg;

  localparam logic [1:0] MODE_FAST = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } clkgen_state_t;

  // FAST and SLOW free-run; STEP and HALT park in IDLE.
  function automatic logic is_run(input logic [1:0] m);
    return (m == MODE_FAST) || (m == MODE_SLOW);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// One-bit registered rising-edge detector,
// synchronous active-high reset.
module rise_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_edge
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_edge = i_d & ~r_q;

endmodule

// File: rtl/cpu_clk_gen.sv
// Programmable CPU clock generator: fast, slow,
// single-step and halt, switching on period boundaries.
module cpu_clk_gen #(
  parameter int HALF_W = 26,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [HALF_W-1:0] half_period,
  input  logic              step,
  output logic              clk_cpu,
  output logic              cpu_en,
  output logic [1:0]        applied_mode,
  output logic [CNT_W-1:0]  cycle_cnt
);

  import cpu_clk_gen_pkg::*;

  clkgen_state_t     r_state;
  clkgen_state_t     w_state_nxt;
  logic [HALF_W-1:0] r_cnt;
  logic [HALF_W-1:0] r_hlen;
  logic [HALF_W-1:0] w_len;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [1:0]        r_amode;
  logic              r_clk_cpu;
  logic              r_cpu_en;
  logic              w_step_edge;
  logic              w_run;
  logic              w_cnt_one;
  logic              w_rise;
  logic              w_fall;
  logic              w_stop;

  rise_edge_det u_step_det (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_d    (step),
    .o_edge (w_step_edge)
  );

  assign w_run     = is_run(mode);
  assign w_cnt_one = (r_cnt == HALF_W'(1));

  // A zero half-period would never count out.
  always_comb begin
    w_len = HALF_W'(1);
    if (mode == MODE_SLOW && half_period != '0)
      w_len = half_period;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_stop      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_run || (mode == MODE_STEP && w_step_edge))
          w_rise = 1'b1;
      end
      ST_HIGH: begin
        if (w_cnt_one) w_fall = 1'b1;
      end
      ST_LOW: begin
        if (w_cnt_one) begin
          if (w_run) w_rise = 1'b1;
          else       w_stop = 1'b1;
        end
      end
      default: w_stop = 1'b1;
    endcase
    if (w_rise)      w_state_nxt = ST_HIGH;
    else if (w_fall) w_state_nxt = ST_LOW;
    else if (w_stop) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cpu   <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_cycle_cnt <= '0;
      r_amode     <= MODE_HALT;
      r_cnt       <= '0;
      r_hlen      <= '0;
    end else begin
      r_cpu_en <= w_rise;
      if (w_rise) begin
        r_clk_cpu   <= 1'b1;
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        r_amode     <= mode;
        r_hlen      <= w_len;
        r_cnt       <= w_len;
      end else if (w_fall) begin
        r_clk_cpu <= 1'b0;
        r_cnt     <= r_hlen;
      end else if (w_stop) begin
        r_amode <= mode;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt - HALF_W'(1);
      end
    end
  end

  assign clk_cpu      = r_clk_cpu;
  assign cpu_en       = r_cpu_en;
  assign applied_mode = r_amode;
  assign cycle_cnt    = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen: period-position reference model,
// directed literal checks and randomized mode/step traffic.
module tb_cpu_clk_gen;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] half_period;
  logic       step;
  logic       clk_cpu;
  logic       cpu_en;
  logic [1:0] applied_mode;
  logic [7:0] cycle_cnt;

  int n_tot  = 0;
  int n_pass = 0;

  cpu_clk_gen #(.HALF_W(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .half_period  (half_period),
    .step         (step),
    .clk_cpu      (clk_cpu),
    .cpu_en       (cpu_en),
    .applied_mode (applied_mode),
    .cycle_cnt    (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // Model: a period is 2*len cycles starting at a rise;
  // position within it decides the outputs.
  bit         m_init = 0;
  bit         m_act  = 0;
  int         m_pos  = 0;
  int         m_len  = 1;
  logic [7:0] m_cnt  = '0;
  logic [1:0] m_am   = 2'b11;
  bit         m_sp   = 0;
  bit         m_go;
  bit         m_edge;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_act = 0; m_pos = 0;
      m_cnt = '0; m_am = 2'b11; m_sp = 0;
    end else begin
      m_edge = step && !m_sp;
      m_go   = 0;
      if (!m_act) begin
        m_go = (mode < 2) || (mode == 2 && m_edge);
      end else if (m_pos == 2 * m_len - 1) begin
        if (mode < 2) m_go = 1;
        else begin m_act = 0; m_am = mode; end
      end else begin
        m_pos++;
      end
      if (m_go) begin
        m_act = 1;
        m_pos = 0;
        m_len = (mode == 1 && half_period != 0) ? int'(half_period) : 1;
        m_cnt = m_cnt + 8'd1;
        m_am  = mode;
      end
      m_sp = step;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("clk_cpu", int'(clk_cpu), int'(m_act && m_pos < m_len));
      chk("cpu_en", int'(cpu_en), int'(m_act && m_pos == 0));
      chk("cycle_cnt", int'(cycle_cnt), int'(m_cnt));
      chk("applied_mode", int'(applied_mode), int'(m_am));
    end
  end

  task automatic wait_rise();
    int n = 0;
    @(negedge clk);
    while (!cpu_en && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cpu_en) chk("wait_rise_timeout", 0, 1);
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (clk_cpu && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  int hi;
  logic [7:0] c0;

  initial begin
    rst = 1; mode = 2'b00; step = 0; half_period = 8'd3;
    repeat (3) @(negedge clk);
    chk("rst_clk_cpu", int'(clk_cpu), 0);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_cnt", int'(cycle_cnt), 0);
    chk("rst_amode", int'(applied_mode), 3);
    rst = 0;
    @(negedge clk);
    chk("fast_first_rise", int'(clk_cpu), 1);
    repeat (19) @(negedge clk);
    chk("fast_cnt20", int'(cycle_cnt), 10);

    mode = 2'b01;
    wait_rise(); count_high(hi);
    chk("slow3_high", hi, 3);
    wait_rise(); half_period = 8'd5; count_high(hi);
    chk("slow_mid_change", hi, 3);
    wait_rise(); count_high(hi);
    chk("slow5_high", hi, 5);
    half_period = 8'd0;
    wait_rise(); count_high(hi);
    chk("slow0_high", hi, 1);

    mode = 2'b10;
    repeat (12) @(negedge clk);
    c0 = cycle_cnt;
    for (int i = 0; i < 3; i++) begin
      step = 1; @(negedge clk);
      step = 0; repeat (3) @(negedge clk);
    end
    chk("step_three", int'(cycle_cnt - c0), 3);
    c0 = cycle_cnt;
    step = 1; repeat (10) @(negedge clk);
    step = 0; repeat (4) @(negedge clk);
    chk("step_held", int'(cycle_cnt - c0), 1);
    c0 = cycle_cnt;
    step = 1; @(negedge clk);
    step = 0; @(negedge clk);
    step = 1; repeat (6) @(negedge clk);
    step = 0; repeat (2) @(negedge clk);
    chk("step_drop_busy", int'(cycle_cnt - c0), 1);

    mode = 2'b01; half_period = 8'd4;
    wait_rise(); @(negedge clk);
    mode = 2'b11;
    count_high(hi);
    chk("halt_high", hi + 1, 4);
    chk("halt_low_amode", int'(applied_mode), 1);
    repeat (20) @(negedge clk);
    chk("halt_parked", int'(clk_cpu), 0);
    chk("halt_amode", int'(applied_mode), 3);
    mode = 2'b00;
    @(negedge clk);
    chk("halt_to_fast", int'(clk_cpu), 1);

    wait_rise(); @(negedge clk);
    mode = 2'b01; half_period = 8'd2;
    @(negedge clk);
    chk("f2s_rise", int'(clk_cpu), 1);
    chk("f2s_amode", int'(applied_mode), 1);
    count_high(hi);
    chk("f2s_high", hi, 2);

    half_period = 8'd4;
    wait_rise();
    rst = 1; @(negedge clk);
    chk("mid_rst_clk", int'(clk_cpu), 0);
    chk("mid_rst_en", int'(cpu_en), 0);
    chk("mid_rst_cnt", int'(cycle_cnt), 0);
    mode = 2'b00; rst = 0;
    repeat (520) @(negedge clk);
    chk("wrap_cnt", int'(cycle_cnt), 4);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) half_period = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) step = ~step;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
